// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store data port.
// Holds RV32I funct3 size codes, the port FSM state type and the lane/fault helpers.
// Used by the top and the load-align sub-module.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] byteen_f(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Illegal size code, unsigned store, or an address not aligned to the access size.
  function automatic logic fault_f(input logic we, input logic [2:0] funct3, input logic [1:0] off);
    logic f;
    case (funct3)
      F3_B, F3_BU: f = 1'b0;
      F3_H, F3_HU: f = off[0];
      F3_W:        f = (off != 2'd0);
      default:     f = 1'b1;
    endcase
    return f | (we & (funct3 > F3_W));
  endfunction

  // Store data replicated across every lane so the byte enables alone select the target.
  function automatic logic [31:0] wdata_f(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] w;
    case (funct3)
      F3_B:    w = {4{wdata[7:0]}};
      F3_H:    w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_data_port_if.sv
// Core-side request/response bundle of the load/store data port.
// master = core (drives requests), slave = load/store unit (drives ready and responses).
// Responses carry no backpressure; the core always takes them.
interface lsu_data_port_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_misaligned;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
  );
endinterface

// File: rtl/lsu_load_align.sv
// Aligns a RAM word to the addressed byte/half and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;
  assign shifted = rdata_i >> {off_i, 3'b000};

  // Pick the low byte/half of the shifted word and extend it per the size code.
  always_comb begin
    result_o = '0;
    case (funct3_i)
      F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result_o = {24'd0, shifted[7:0]};
      F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result_o = {16'd0, shifted[15:0]};
      F3_W:    result_o = shifted;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store unit between the core and a word-wide synchronous data RAM.
// Latency: fault 1, store 2, load 2+MEM_LATENCY cycles from accept to rsp_valid.
// Backpressure: one request in flight; req_ready is low from accept until the cycle after the response.
module lsu_data_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_data_port_if.slave    core,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_byteen,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Counter start so that the capture edge lands MEM_LATENCY cycles after the read strobe.
  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  lsu_state_t        state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [3:0]        mem_byteen_q;
  logic              mem_wren_q;
  logic              mem_rden_q;
  logic [31:0]       mem_wdata_q;
  logic              rsp_valid_q;
  logic              rsp_mis_q;
  logic [31:0]       rsp_rdata_q;

  logic              fault_d;
  logic [3:0]        byteen_d;
  logic [31:0]       wdata_d;
  logic [31:0]       rsp_rdata_d;

  assign fault_d  = fault_f(core.req_we, core.req_funct3, core.req_addr[1:0]);
  assign byteen_d = byteen_f(core.req_funct3, core.req_addr[1:0]);
  assign wdata_d  = wdata_f(core.req_funct3, core.req_wdata);

  lsu_load_align u_align (
    .rdata_i  (mem_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .result_o (rsp_rdata_d)
  );

  // Request FSM; every RAM and response output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_byteen_q <= '0;
      mem_wren_q   <= 1'b0;
      mem_rden_q   <= 1'b0;
      mem_wdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_mis_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      // Strobes and the response are single-cycle pulses unless set below.
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (core.req_valid) begin
            we_q  <= core.req_we;
            f3_q  <= core.req_funct3;
            off_q <= core.req_addr[1:0];
            if (fault_d) begin
              // Faulting requests answer immediately and never reach the RAM.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_mis_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q      <= ACCESS;
              mem_addr_q   <= core.req_addr[ADDR_W-1:2];
              mem_byteen_q <= byteen_d;
              mem_wdata_q  <= wdata_d;
              mem_wren_q   <= core.req_we;
              mem_rden_q   <= ~core.req_we;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_mis_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= WAIT_RD;
            cnt_q   <= CNT_INIT;
          end
        end
        WAIT_RD: begin
          if (cnt_q == 3'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_mis_q   <= 1'b0;
            rsp_rdata_q <= rsp_rdata_d;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign core.req_ready      = (state_q == IDLE);
  assign core.rsp_valid      = rsp_valid_q;
  assign core.rsp_rdata      = rsp_rdata_q;
  assign core.rsp_misaligned = rsp_mis_q;
  assign mem_addr            = mem_addr_q;
  assign mem_byteen          = mem_byteen_q;
  assign mem_wren            = mem_wren_q;
  assign mem_rden            = mem_rden_q;
  assign mem_wdata           = mem_wdata_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port: three instances (RAM latency 1, 3, 7) driven with identical requests.
// Each instance has its own RAM model; a byte-level reference memory predicts loads and stores.
// Directed cases plus randomized requests; checks timing, strobes, lane data and reset behaviour.
module tb_lsu_data_port;

  localparam int ADDR_W = 10;
  localparam int NI     = 3;
  localparam int NCYC   = 12;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 7;
  endfunction

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid  = 1'b0;
  logic              req_we     = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [ADDR_W-1:0] req_addr   = '0;
  logic [31:0]       req_wdata  = '0;

  wire [NI-1:0]       req_ready_a, rsp_valid_a, rsp_mis_a, wren_a, rden_a;
  wire [NI-1:0][31:0] rsp_rdata_a, wdata_a, rdata_a;
  wire [NI-1:0][7:0]  maddr_a;
  wire [NI-1:0][3:0]  be_a;

  logic [31:0] ram  [NI][256] = '{default: '0};
  logic [31:0] pipe [NI][7]   = '{default: '0};
  logic [7:0]  ref_bytes [1024] = '{default: '0};

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 7;
    lsu_data_port_if #(.ADDR_W(ADDR_W)) bus ();
    assign bus.req_valid  = req_valid;
    assign bus.req_we     = req_we;
    assign bus.req_funct3 = req_funct3;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign req_ready_a[g] = bus.req_ready;
    assign rsp_valid_a[g] = bus.rsp_valid;
    assign rsp_mis_a[g]   = bus.rsp_misaligned;
    assign rsp_rdata_a[g] = bus.rsp_rdata;
    assign rdata_a[g]     = pipe[g][L-1];
    lsu_data_port #(.ADDR_W(ADDR_W), .MEM_LATENCY(L)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .core       (bus),
      .mem_addr   (maddr_a[g]),
      .mem_byteen (be_a[g]),
      .mem_wren   (wren_a[g]),
      .mem_rden   (rden_a[g]),
      .mem_wdata  (wdata_a[g]),
      .mem_rdata  (rdata_a[g])
    );
  end

  // RAM models: byte-enabled write, read data delivered MEM_LATENCY cycles after rden.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (wren_a[i])
        for (int b = 0; b < 4; b++)
          if (be_a[i][b]) ram[i][maddr_a[i]][8*b +: 8] <= wdata_a[i][8*b +: 8];
      pipe[i][0] <= rden_a[i] ? ram[i][maddr_a[i]] : 32'h5A5A0F0F;
      for (int k = 1; k < 7; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  task automatic model_xact(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                            input logic [31:0] wd, output logic fault, output logic [31:0] rd,
                            output logic [3:0] be, output logic [31:0] mwd);
    int size;
    longint v;
    logic [31:0] mask, mult;
    size  = 1 << (int'(f3) % 4);
    fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 > 3'd2) ||
            (int'(addr) % size != 0);
    rd = '0; be = '0; mwd = '0;
    if (!fault) begin
      be   = 4'(((1 << size) - 1) << (int'(addr) % 4));
      mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8*size)) - 32'd1);
      mult = (size == 1) ? 32'h01010101 : (size == 2) ? 32'h00010001 : 32'h00000001;
      mwd  = (wd & mask) * mult;
      if (we) begin
        for (int b = 0; b < size; b++) ref_bytes[int'(addr)+b] = 8'(wd >> (8*b));
      end else begin
        v = 0;
        for (int b = 0; b < size; b++) v = v | (longint'(ref_bytes[int'(addr)+b]) << (8*b));
        if (f3 < 3'd4 && size < 4 && ((v >> (8*size-1)) & 1) == 1) v = v - (longint'(1) << (8*size));
        rd = v[31:0];
      end
    end
  endtask

  // ---------------- transaction driver / observer ----------------
  int          o_nrsp [NI], o_rcyc [NI], o_nwr [NI], o_nrd [NI], o_scyc [NI];
  logic [31:0] o_rdata [NI], o_wd [NI];
  logic        o_mis [NI], o_rdy [NI];
  logic [3:0]  o_be [NI];
  logic [7:0]  o_addr [NI];

  task automatic do_xact(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                         input logic [31:0] wd, input bit junk);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      o_nrsp[i] = 0; o_rcyc[i] = 0; o_nwr[i] = 0; o_nrd[i] = 0; o_scyc[i] = 0;
      o_rdata[i] = 'x; o_wd[i] = 'x; o_mis[i] = 'x; o_rdy[i] = 1'b0; o_be[i] = 'x; o_addr[i] = 'x;
    end
    for (int k = 1; k <= NCYC; k++) begin
      @(negedge clk);
      if (junk) begin
        req_valid = (k <= 3); req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 10'h3F0; req_wdata = 32'hFFFFFFFF;
      end
      for (int i = 0; i < NI; i++) begin
        if (o_rcyc[i] != 0 && k == o_rcyc[i] + 1) o_rdy[i] = req_ready_a[i];
        if (rsp_valid_a[i]) begin
          o_nrsp[i]++; o_rcyc[i] = k; o_rdata[i] = rsp_rdata_a[i]; o_mis[i] = rsp_mis_a[i];
        end
        if (wren_a[i] || rden_a[i]) begin
          o_nwr[i] += int'(wren_a[i]); o_nrd[i] += int'(rden_a[i]); o_scyc[i] = k;
          o_be[i] = be_a[i]; o_addr[i] = maddr_a[i]; o_wd[i] = wdata_a[i];
        end
      end
    end
    req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (req_ready_a[i] !== 1'b1 || rsp_valid_a[i] !== 1'b0 || rsp_mis_a[i] !== 1'b0 ||
          wren_a[i] !== 1'b0 || rden_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl L%0d: got rdy/rsp/mis/wr/rd=%b%b%b%b%b, expected 10000", lat_of(i),
                 req_ready_a[i], rsp_valid_a[i], rsp_mis_a[i], wren_a[i], rden_a[i]);
      end
      checks++;
      if (maddr_a[i] !== 8'd0 || be_a[i] !== 4'd0 || wdata_a[i] !== 32'd0 || rsp_rdata_a[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_data L%0d: got addr=%h be=%h wd=%h rd=%h, expected all 0", lat_of(i),
                 maddr_a[i], be_a[i], wdata_a[i], rsp_rdata_a[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wd;
  } xact_t;

  task automatic test_load_store(input int n_rand);
    xact_t q[$];
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic fault;
    logic [31:0] rd, mwd;
    logic [3:0] be;
    int r, exp_cyc, exp_nwr, exp_nrd;
    q.push_back('{1'b1, 3'd2, 10'h008, 32'hDEADBEEF});
    q.push_back('{1'b1, 3'd0, 10'h00D, 32'h123456A5});
    q.push_back('{1'b0, 3'd4, 10'h00D, 32'h0});
    q.push_back('{1'b0, 3'd0, 10'h00D, 32'h0});
    q.push_back('{1'b1, 3'd2, 10'h008, 32'h80011234});
    q.push_back('{1'b0, 3'd1, 10'h00A, 32'h0});
    q.push_back('{1'b0, 3'd5, 10'h00A, 32'h0});
    q.push_back('{1'b0, 3'd2, 10'h006, 32'h0});
    q.push_back('{1'b1, 3'd1, 10'h003, 32'h0000CAFE});
    q.push_back('{1'b0, 3'd3, 10'h010, 32'h0});
    q.push_back('{1'b1, 3'd4, 10'h010, 32'h77777777});
    q.push_back('{1'b1, 3'd2, 10'h3FC, 32'h0BADF00D});
    q.push_back('{1'b0, 3'd2, 10'h3FC, 32'h0});
    for (int n = 0; n < n_rand; n++) begin
      r = $urandom_range(0, 15);
      q.push_back('{1'($urandom_range(0, 1)),
                    (r < 14) ? legal[r % 5] : (r == 14) ? 3'd3 : 3'd7,
                    10'($urandom_range(0, 47)), $urandom});
    end
    foreach (q[t]) begin
      model_xact(q[t].we, q[t].f3, q[t].addr, q[t].wd, fault, rd, be, mwd);
      do_xact(q[t].we, q[t].f3, q[t].addr, q[t].wd, 1'b0);
      for (int i = 0; i < NI; i++) begin
        exp_cyc = fault ? 1 : q[t].we ? 2 : 2 + lat_of(i);
        exp_nwr = (!fault && q[t].we) ? 1 : 0;
        exp_nrd = (!fault && !q[t].we) ? 1 : 0;
        checks++;
        if (o_nrsp[i] !== 1 || o_rcyc[i] !== exp_cyc) begin
          errors++;
          $display("FAIL rsp_timing #%0d L%0d: got %0d pulses at cycle %0d, expected 1 at %0d",
                   t, lat_of(i), o_nrsp[i], o_rcyc[i], exp_cyc);
        end
        checks++;
        if (o_mis[i] !== fault || o_rdata[i] !== rd) begin
          errors++;
          $display("FAIL rsp_data #%0d L%0d: got mis=%b rdata=%h, expected mis=%b rdata=%h",
                   t, lat_of(i), o_mis[i], o_rdata[i], fault, rd);
        end
        checks++;
        if (o_rdy[i] !== 1'b1) begin
          errors++;
          $display("FAIL ready_after #%0d L%0d: got %b, expected 1", t, lat_of(i), o_rdy[i]);
        end
        checks++;
        if (o_nwr[i] !== exp_nwr || o_nrd[i] !== exp_nrd) begin
          errors++;
          $display("FAIL strobes #%0d L%0d: got wr=%0d rd=%0d, expected wr=%0d rd=%0d",
                   t, lat_of(i), o_nwr[i], o_nrd[i], exp_nwr, exp_nrd);
        end
        if (!fault) begin
          checks++;
          if (o_scyc[i] !== 1 || o_be[i] !== be || o_addr[i] !== q[t].addr[9:2]) begin
            errors++;
            $display("FAIL access #%0d L%0d: got cyc=%0d be=%b addr=%h, expected cyc=1 be=%b addr=%h",
                     t, lat_of(i), o_scyc[i], o_be[i], o_addr[i], be, q[t].addr[9:2]);
          end
          if (q[t].we) begin
            checks++;
            if (o_wd[i] !== mwd) begin
              errors++;
              $display("FAIL mem_wdata #%0d L%0d: got %h, expected %h", t, lat_of(i), o_wd[i], mwd);
            end
          end
        end
        checks++;
        if (ram[i][q[t].addr[9:2]] !== ref_word(int'(q[t].addr[9:2]))) begin
          errors++;
          $display("FAIL ram_word #%0d L%0d: got %h, expected %h", t, lat_of(i),
                   ram[i][q[t].addr[9:2]], ref_word(int'(q[t].addr[9:2])));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic fault;
    logic [31:0] rd, mwd0, mwd1;
    logic [3:0] be0, be1;
    int nwr [NI], wr1 [NI], wr2 [NI], nrsp [NI], rs1 [NI], rs2 [NI];
    logic [3:0] be2 [NI];
    logic [31:0] wd2 [NI];
    model_xact(1'b1, 3'd2, 10'h040, 32'hA1B2C3D4, fault, rd, be0, mwd0);
    model_xact(1'b1, 3'd1, 10'h046, 32'h1234BEEF, fault, rd, be1, mwd1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 10'h040; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_funct3 = 3'd1; req_addr = 10'h046; req_wdata = 32'h1234BEEF;
    for (int i = 0; i < NI; i++) begin nwr[i] = 0; nrsp[i] = 0; wr1[i] = 0; wr2[i] = 0; rs1[i] = 0; rs2[i] = 0; end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) req_valid = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (wren_a[i]) begin
          nwr[i]++;
          if (nwr[i] == 1) wr1[i] = k;
          else begin wr2[i] = k; be2[i] = be_a[i]; wd2[i] = wdata_a[i]; end
        end
        if (rsp_valid_a[i]) begin
          nrsp[i]++;
          if (nrsp[i] == 1) rs1[i] = k; else rs2[i] = k;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (nwr[i] !== 2 || wr1[i] !== 1 || wr2[i] !== 4) begin
        errors++;
        $display("FAIL b2b_wren L%0d: got %0d writes at %0d,%0d, expected 2 at 1,4", lat_of(i), nwr[i], wr1[i], wr2[i]);
      end
      checks++;
      if (nrsp[i] !== 2 || rs1[i] !== 2 || rs2[i] !== 5) begin
        errors++;
        $display("FAIL b2b_rsp L%0d: got %0d rsps at %0d,%0d, expected 2 at 2,5", lat_of(i), nrsp[i], rs1[i], rs2[i]);
      end
      checks++;
      if (be2[i] !== be1 || wd2[i] !== mwd1) begin
        errors++;
        $display("FAIL b2b_second L%0d: got be=%b wd=%h, expected be=%b wd=%h", lat_of(i), be2[i], wd2[i], be1, mwd1);
      end
      checks++;
      if (ram[i][16] !== ref_word(16) || ram[i][17] !== ref_word(17)) begin
        errors++;
        $display("FAIL b2b_ram L%0d: got %h %h, expected %h %h", lat_of(i), ram[i][16], ram[i][17], ref_word(16), ref_word(17));
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic fault;
    logic [31:0] rd, mwd;
    logic [3:0] be;
    model_xact(1'b0, 3'd2, 10'h040, 32'h0, fault, rd, be, mwd);
    do_xact(1'b0, 3'd2, 10'h040, 32'h0, 1'b1);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_nrsp[i] !== 1 || o_rcyc[i] !== 2 + lat_of(i) || o_rdata[i] !== rd) begin
        errors++;
        $display("FAIL busy_rsp L%0d: got %0d rsps at %0d data %h, expected 1 at %0d data %h",
                 lat_of(i), o_nrsp[i], o_rcyc[i], o_rdata[i], 2 + lat_of(i), rd);
      end
      checks++;
      if (o_nwr[i] !== 0 || o_nrd[i] !== 1 || ram[i][252] !== ref_word(252)) begin
        errors++;
        $display("FAIL busy_strobes L%0d: got wr=%0d rd=%0d ram=%h, expected wr=0 rd=1 ram=%h",
                 lat_of(i), o_nwr[i], o_nrd[i], ram[i][252], ref_word(252));
      end
    end
  endtask

  task automatic test_reset_mid;
    int extra [NI];
    // Reset lands on the accept edge of a store: the store is dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 10'h020; req_wdata = 32'h11223344;
    rst_n = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (wren_a[i] !== 1'b0 || rden_a[i] !== 1'b0 || req_ready_a[i] !== 1'b1 || rsp_valid_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_store L%0d: got wr/rd/rdy/rsp=%b%b%b%b, expected 0010", lat_of(i),
                 wren_a[i], rden_a[i], req_ready_a[i], rsp_valid_a[i]);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ram[i][8] !== ref_word(8)) begin
        errors++;
        $display("FAIL rst_ram L%0d: got %h, expected %h", lat_of(i), ram[i][8], ref_word(8));
      end
    end
    // Reset while a load waits for RAM data: no response ever appears.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 10'h008; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) extra[i] = 0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NI; i++) extra[i] += int'(rsp_valid_a[i]);
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (extra[i] !== 0 || req_ready_a[i] !== 1'b1 || rsp_rdata_a[i] !== 32'd0) begin
        errors++;
        $display("FAIL rst_load L%0d: got rsps=%0d rdy=%b rdata=%h, expected 0 1 00000000",
                 lat_of(i), extra[i], req_ready_a[i], rsp_rdata_a[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_load_store(40);
    test_back_to_back;
    test_reset_mid;
    test_busy_ignore;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
